// File: rtl/reg_file_2r1w.sv
// reg_file_2r1w
// Architectural register file: 32 x DATA_WIDTH general-purpose registers with
// two combinational read ports, one synchronous write port, and a
// combinational debug observation port.
//
// Ports:
//   Clk           - clock; writes commit on the rising edge
//   Rst           - asynchronous, active-high reset
//   ReadRegister1 - read address A (rs)
//   ReadRegister2 - read address B (rt)
//   WriteRegister - write-back destination register number
//   WriteData     - write-back result
//   RegWrite      - write-back enable
//   DebugRegister - observation-port address
//   ReadData1     - contents at ReadRegister1, with same-cycle write bypass
//   ReadData2     - contents at ReadRegister2, with same-cycle write bypass
//   DebugData     - stored contents at DebugRegister, never bypassed
module reg_file_2r1w #(
   parameter int                    DATA_WIDTH = 32,
   parameter logic [DATA_WIDTH-1:0] SP_RESET   = '0
) (
   input  logic                  Clk,
   input  logic                  Rst,
   input  logic [4:0]            ReadRegister1,
   input  logic [4:0]            ReadRegister2,
   input  logic [4:0]            WriteRegister,
   input  logic [DATA_WIDTH-1:0] WriteData,
   input  logic                  RegWrite,
   input  logic [4:0]            DebugRegister,
   output logic [DATA_WIDTH-1:0] ReadData1,
   output logic [DATA_WIDTH-1:0] ReadData2,
   output logic [DATA_WIDTH-1:0] DebugData
);

   localparam logic [4:0] SP_INDEX = 5'd29;

   logic [DATA_WIDTH-1:0] r_regs [32];

   logic w_wr_en;
   logic w_bypass1;
   logic w_bypass2;

   // Entry 0 is never written, so it holds its reset value of zero; reads of
   // address 0 are still forced to zero explicitly below.
   assign w_wr_en = RegWrite && (WriteRegister != 5'd0);

   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         for (int i = 0; i < 32; i++) begin
            r_regs[i] <= (5'(i) == SP_INDEX) ? SP_RESET : '0;
         end
      end else if (w_wr_en) begin
         r_regs[WriteRegister] <= WriteData;
      end
   end

   // Bypass lets ID see the value retiring this cycle. It is suppressed
   // during reset so the outputs follow the cleared storage immediately.
   assign w_bypass1 = RegWrite && !Rst && (WriteRegister == ReadRegister1);
   assign w_bypass2 = RegWrite && !Rst && (WriteRegister == ReadRegister2);

   always_comb begin
      ReadData1 = r_regs[ReadRegister1];
      if (ReadRegister1 == 5'd0) begin
         ReadData1 = '0;
      end else if (w_bypass1) begin
         ReadData1 = WriteData;
      end
   end

   always_comb begin
      ReadData2 = r_regs[ReadRegister2];
      if (ReadRegister2 == 5'd0) begin
         ReadData2 = '0;
      end else if (w_bypass2) begin
         ReadData2 = WriteData;
      end
   end

   assign DebugData = (DebugRegister == 5'd0) ? '0 : r_regs[DebugRegister];

endmodule

// File: tb/tb_reg_file_2r1w.sv
// Directed testbench for reg_file_2r1w. Inputs change on the falling edge;
// outputs are sampled 1 time unit later, well away from the rising edge.
module tb_reg_file_2r1w;

   localparam int          DW = 32;
   localparam logic [31:0] SP = 32'h7FFF_FFFC;

   logic          Clk = 1'b0;
   logic          Rst;
   logic [4:0]    ReadRegister1;
   logic [4:0]    ReadRegister2;
   logic [4:0]    WriteRegister;
   logic [DW-1:0] WriteData;
   logic          RegWrite;
   logic [4:0]    DebugRegister;
   logic [DW-1:0] ReadData1;
   logic [DW-1:0] ReadData2;
   logic [DW-1:0] DebugData;

   int checks = 0;
   int errors = 0;

   reg_file_2r1w #(.DATA_WIDTH(DW), .SP_RESET(SP)) dut (
      .Clk           (Clk),
      .Rst           (Rst),
      .ReadRegister1 (ReadRegister1),
      .ReadRegister2 (ReadRegister2),
      .WriteRegister (WriteRegister),
      .WriteData     (WriteData),
      .RegWrite      (RegWrite),
      .DebugRegister (DebugRegister),
      .ReadData1     (ReadData1),
      .ReadData2     (ReadData2),
      .DebugData     (DebugData)
   );

   always #5 Clk = ~Clk;

   task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Single committed write: enable is held across exactly one rising edge.
   task automatic do_write(input logic [4:0] a, input logic [DW-1:0] d);
      @(negedge Clk);
      WriteRegister = a;
      WriteData     = d;
      RegWrite      = 1'b1;
      @(negedge Clk);
      RegWrite      = 1'b0;
   endtask

   initial begin
      Rst           = 1'b1;
      ReadRegister1 = 5'd0;
      ReadRegister2 = 5'd0;
      WriteRegister = 5'd0;
      WriteData     = '0;
      RegWrite      = 1'b0;
      DebugRegister = 5'd0;
      repeat (2) @(negedge Clk);
      Rst = 1'b0;

      // Populate registers so the mid-cycle reset has something to clear.
      do_write(5'd5,  32'h1111_1111);
      do_write(5'd31, 32'h3131_3131);
      do_write(5'd29, 32'h2929_2929);
      #1;
      DebugRegister = 5'd5;
      #1 chk("pre_reset_r5", DebugData, 32'h1111_1111);

      // Asynchronous reset pulse in the middle of the low phase.
      #1 Rst = 1'b1;
      #1;
      for (int i = 0; i < 32; i++) begin
         DebugRegister = 5'(i);
         #1 chk($sformatf("reset_dbg_%0d", i), DebugData, (i == 29) ? SP : 32'h0);
      end
      ReadRegister1 = 5'd0;  ReadRegister2 = 5'd5;
      #1 chk("reset_rd1_a0", ReadData1, 32'h0);
      chk("reset_rd2_a5", ReadData2, 32'h0);
      ReadRegister1 = 5'd31; ReadRegister2 = 5'd31;
      #1 chk("reset_rd1_a31", ReadData1, 32'h0);
      chk("reset_rd2_a31", ReadData2, 32'h0);
      @(negedge Clk);
      Rst = 1'b0;

      // Basic write/read and debug port write latency.
      WriteRegister = 5'd8; WriteData = 32'hDEAD_BEEF; RegWrite = 1'b1;
      DebugRegister = 5'd8;
      #1 chk("dbg8_before_edge", DebugData, 32'h0);
      @(negedge Clk);
      RegWrite = 1'b0; ReadRegister1 = 5'd8;
      #1 chk("rd1_r8", ReadData1, 32'hDEAD_BEEF);
      chk("dbg8_after_edge", DebugData, 32'hDEAD_BEEF);

      // Register 0 protection, same cycle and after the edge.
      @(negedge Clk);
      RegWrite = 1'b1; WriteRegister = 5'd0; WriteData = 32'hFFFF_FFFF;
      ReadRegister1 = 5'd0; ReadRegister2 = 5'd0; DebugRegister = 5'd0;
      #1 chk("r0_rd1_same", ReadData1, 32'h0);
      chk("r0_rd2_same", ReadData2, 32'h0);
      chk("r0_dbg_same", DebugData, 32'h0);
      @(negedge Clk);
      RegWrite = 1'b0;
      #1 chk("r0_rd1_after", ReadData1, 32'h0);
      chk("r0_rd2_after", ReadData2, 32'h0);
      chk("r0_dbg_after", DebugData, 32'h0);
      ReadRegister1 = 5'd8;
      #1 chk("r8_unchanged_by_r0", ReadData1, 32'hDEAD_BEEF);

      // Same-cycle bypass on both ports.
      do_write(5'd9, 32'd5);
      WriteRegister = 5'd9; WriteData = 32'd7; RegWrite = 1'b1;
      ReadRegister1 = 5'd9; ReadRegister2 = 5'd9; DebugRegister = 5'd9;
      #1 chk("byp_rd1", ReadData1, 32'd7);
      chk("byp_rd2", ReadData2, 32'd7);
      chk("byp_dbg_no_bypass", DebugData, 32'd5);
      RegWrite = 1'b0;
      #1 chk("nobyp_rd1", ReadData1, 32'd5);
      chk("nobyp_rd2", ReadData2, 32'd5);

      // Ports resolve independently: only port 2 matches the write address.
      ReadRegister2 = 5'd8; WriteRegister = 5'd8; WriteData = 32'h0000_1234;
      RegWrite = 1'b1;
      #1 chk("indep_rd1", ReadData1, 32'd5);
      chk("indep_rd2", ReadData2, 32'h0000_1234);
      RegWrite = 1'b0;
      #1 chk("indep_rd2_off", ReadData2, 32'hDEAD_BEEF);

      // Let the bypassed write commit and confirm storage matches.
      WriteRegister = 5'd9; WriteData = 32'd7; RegWrite = 1'b1;
      @(negedge Clk);
      RegWrite = 1'b0; DebugRegister = 5'd9;
      #1 chk("byp_commit_dbg9", DebugData, 32'd7);

      // Link destination and neighbour isolation.
      do_write(5'd31, 32'h0040_0010);
      ReadRegister2 = 5'd31;
      #1 chk("link_rd2_r31", ReadData2, 32'h0040_0010);
      do_write(5'd30, 32'hAAAA_5555);
      ReadRegister1 = 5'd30;
      #1 chk("link_r31_kept", ReadData2, 32'h0040_0010);
      chk("link_r30", ReadData1, 32'hAAAA_5555);

      // Back-to-back writes to one register: last write wins.
      @(negedge Clk);
      WriteRegister = 5'd10; WriteData = 32'd1; RegWrite = 1'b1; DebugRegister = 5'd10;
      @(negedge Clk);
      WriteData = 32'd2;
      #1 chk("b2b_first", DebugData, 32'd1);
      @(negedge Clk);
      RegWrite = 1'b0;
      #1 chk("b2b_last", DebugData, 32'd2);

      // Reset held across a pending write: write discarded, bypass suppressed.
      @(negedge Clk);
      WriteRegister = 5'd12; WriteData = 32'd3; RegWrite = 1'b1;
      ReadRegister1 = 5'd12; DebugRegister = 5'd29;
      Rst = 1'b1;
      #1 chk("rst_wr_no_bypass", ReadData1, 32'h0);
      chk("rst_wr_sp", DebugData, SP);
      @(negedge Clk);
      DebugRegister = 5'd12;
      #1 chk("rst_wr_r12_dropped", DebugData, 32'h0);
      DebugRegister = 5'd31;
      #1 chk("rst_wr_r31_cleared", DebugData, 32'h0);

      // First write after release lands on the first rising edge.
      Rst = 1'b0;
      DebugRegister = 5'd12;
      @(negedge Clk);
      RegWrite = 1'b0;
      #1 chk("post_rst_first_write", DebugData, 32'd3);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
